// File: rtl/coeff_token_ctrl.sv
// CAVLC coeff_token decode sequencer: picks the VLC table class, counts leading zeros,
// drives the shared LUT bank (or decodes the 6-bit FLC directly) and issues the consume shift.
module coeff_token_ctrl #(
  parameter int WIN_W     = 16,
  parameter int LUTBITS_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [4:0]           nC,
  input  logic                 ChromaDC,
  input  logic [WIN_W-1:0]     BitsIn,
  input  logic                 BitsValid,
  output logic [6:0]           LutSel,
  output logic [LUTBITS_W-1:0] LutBits,
  input  logic [4:0]           LutTotalCoeff,
  input  logic [1:0]           LutTrailingOnes,
  input  logic [4:0]           LutNumShift,
  output logic                 ShiftEn,
  output logic [4:0]           ShiftAmt,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [4:0]           TotalCoeff,
  output logic [1:0]           TrailingOnes
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOOK,
    FLC,
    SHIFT,
    DONE,
    ERR
  } state_t;

  state_t state, nstate;

  logic [2:0]                   cls;
  logic [2:0]                   clsnext;
  logic [4:0]                   lz;
  logic [WIN_W+LUTBITS_W-1:0]   shifted;
  logic [LUTBITS_W-1:0]         afterbits;
  logic                         lutok;
  logic [5:0]                   f;
  logic                         flcesc;
  logic [4:0]                   flctc;
  logic [1:0]                   flct1;
  logic                         flcok;

  assign clsnext = ChromaDC   ? 3'd4 :
                   (nC < 5'd2) ? 3'd0 :
                   (nC < 5'd4) ? 3'd1 :
                   (nC < 5'd8) ? 3'd2 : 3'd3;

  // Leading-zero count: the highest set bit wins, an all-zero window reports 16
  always_comb begin
    lz = 5'd16;
    for (int i = 0; i < WIN_W; i++) begin
      if (BitsIn[i]) lz = 5'(WIN_W - 1 - i);
    end
  end

  // Shifting past the leading '1' zero-fills whatever runs off the bottom of the window
  assign shifted   = {BitsIn, {LUTBITS_W{1'b0}}} << (lz + 5'd1);
  assign afterbits = shifted[WIN_W+LUTBITS_W-1 -: LUTBITS_W];

  assign lutok = (LutNumShift != 5'd0) && (LutNumShift <= 5'd16);

  // 6-bit fixed-length code for nC>=8; 000011 is the escape for zero coefficients
  assign f      = BitsIn[WIN_W-1 -: 6];
  assign flcesc = (f == 6'b000011);
  assign flctc  = flcesc ? 5'd0 : ({1'b0, f[5:2]} + 5'd1);
  assign flct1  = flcesc ? 2'd0 : f[1:0];
  assign flcok  = ({3'b000, flct1} <= flctc);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      cls          <= 3'd0;
      LutSel       <= 7'd0;
      LutBits      <= '0;
      ShiftAmt     <= 5'd0;
      TotalCoeff   <= 5'd0;
      TrailingOnes <= 2'd0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: if (Start) cls <= clsnext;
        WAIT: begin
          if (BitsValid && (cls != 3'd3) && (lz != 5'd16)) begin
            LutSel  <= {cls, lz[3:0]};
            LutBits <= afterbits;
          end
        end
        LOOK: begin
          if (lutok) begin
            TotalCoeff   <= LutTotalCoeff;
            TrailingOnes <= LutTrailingOnes;
            ShiftAmt     <= LutNumShift;
          end
        end
        FLC: begin
          if (flcok) begin
            TotalCoeff   <= flctc;
            TrailingOnes <= flct1;
            ShiftAmt     <= 5'd6;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (Start) nstate = WAIT;
      WAIT: begin
        if (BitsValid) begin
          if (cls == 3'd3)      nstate = FLC;
          else if (lz == 5'd16) nstate = ERR;
          else                  nstate = LOOK;
        end
      end
      LOOK:  nstate = lutok ? SHIFT : ERR;
      FLC:   nstate = flcok ? SHIFT : ERR;
      SHIFT: nstate = DONE;
      DONE:  nstate = IDLE;
      ERR:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Pulses are gated by Rst so a reset landing in SHIFT/DONE never leaks a partial shift
  assign Busy    = (state != IDLE);
  assign ShiftEn = (state == SHIFT) && !Rst;
  assign Done    = ((state == DONE) || (state == ERR)) && !Rst;
  assign Error   = (state == ERR) && !Rst;

endmodule

// File: tb/tb_coeff_token_ctrl.sv
// Directed bench for coeff_token_ctrl with a small mock coeff_token LUT bank.
module tb_coeff_token_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [4:0]  nC;
  logic        ChromaDC;
  logic [15:0] BitsIn;
  logic        BitsValid;
  logic [6:0]  LutSel;
  logic [7:0]  LutBits;
  logic [4:0]  LutTotalCoeff;
  logic [1:0]  LutTrailingOnes;
  logic [4:0]  LutNumShift;
  logic        ShiftEn;
  logic [4:0]  ShiftAmt;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [4:0]  TotalCoeff;
  logic [1:0]  TrailingOnes;

  int assertCount = 0;
  int failCount   = 0;

  int          shCyc, dnCyc;
  logic        errSeen;
  logic [4:0]  amt;
  logic        sawPulse;

  coeff_token_ctrl #(.WIN_W(16), .LUTBITS_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .nC(nC), .ChromaDC(ChromaDC),
    .BitsIn(BitsIn), .BitsValid(BitsValid), .LutSel(LutSel), .LutBits(LutBits),
    .LutTotalCoeff(LutTotalCoeff), .LutTrailingOnes(LutTrailingOnes),
    .LutNumShift(LutNumShift), .ShiftEn(ShiftEn), .ShiftAmt(ShiftAmt), .Busy(Busy),
    .Done(Done), .Error(Error), .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes)
  );

  always #5 Clk = ~Clk;

  // Mock LUT: a few known sub-LUT entries, everything else reports "not in table"
  always_comb begin
    LutTotalCoeff   = 5'd0;
    LutTrailingOnes = 2'd0;
    LutNumShift     = 5'd0;
    case (LutSel)
      7'h00: begin LutTotalCoeff = 5'd0; LutTrailingOnes = 2'd0; LutNumShift = 5'd1; end
      7'h11: if (LutBits == 8'h68) begin
               LutTotalCoeff = 5'd2; LutTrailingOnes = 2'd1; LutNumShift = 5'd5;
             end
      7'h23: begin LutTotalCoeff = 5'd3; LutTrailingOnes = 2'd0; LutNumShift = 5'd17; end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One Start pulse, then watch up to 10 cycles; cycle 1 is the cycle after Start is sampled
  task automatic applyStimulus(input logic [4:0] nc, input logic cd, input logic [15:0] bits,
                               output int sh, output int dn, output logic er,
                               output logic [4:0] am);
    @(posedge Clk);
    #1;
    nC = nc; ChromaDC = cd; BitsIn = bits; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    sh = -1; dn = -1; er = 1'b0; am = 5'd0;
    for (int k = 1; k <= 10 && dn < 0; k++) begin
      @(negedge Clk);
      if (k == 1) checkOutput("busy_in_wait", Busy, 1);
      if (ShiftEn) begin sh = k; am = ShiftAmt; end
      if (Done) begin dn = k; er = Error; end
    end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; nC = 5'd0; ChromaDC = 1'b0; BitsIn = 16'h0000; BitsValid = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_shiften", ShiftEn, 0);
    checkOutput("rst_error", Error, 0);
    checkOutput("rst_shiftamt", ShiftAmt, 0);
    checkOutput("rst_tc", TotalCoeff, 0);
    checkOutput("rst_t1", TrailingOnes, 0);
    checkOutput("rst_lutsel", LutSel, 0);
    checkOutput("rst_lutbits", LutBits, 0);

    // Class 0, Lz=0
    applyStimulus(5'd0, 1'b0, 16'h8000, shCyc, dnCyc, errSeen, amt);
    checkOutput("c0_shift_cycle", shCyc, 3);
    checkOutput("c0_done_cycle", dnCyc, 4);
    checkOutput("c0_error", errSeen, 0);
    checkOutput("c0_shiftamt", amt, 1);
    checkOutput("c0_lutsel", LutSel, 7'h00);
    checkOutput("c0_lutbits", LutBits, 8'h00);
    checkOutput("c0_tc", TotalCoeff, 0);
    checkOutput("c0_t1", TrailingOnes, 0);

    // Class 1 (nC=2), Lz=1, bits after the '1' = 0x68
    applyStimulus(5'd2, 1'b0, 16'h5A00, shCyc, dnCyc, errSeen, amt);
    checkOutput("c1_lutsel", LutSel, 7'h11);
    checkOutput("c1_lutbits", LutBits, 8'h68);
    checkOutput("c1_shift_cycle", shCyc, 3);
    checkOutput("c1_shiftamt", amt, 5);
    checkOutput("c1_tc", TotalCoeff, 2);
    checkOutput("c1_t1", TrailingOnes, 1);

    // FLC 010110 -> TC=6, T1=2
    applyStimulus(5'd9, 1'b0, 16'h5800, shCyc, dnCyc, errSeen, amt);
    checkOutput("flc_shift_cycle", shCyc, 3);
    checkOutput("flc_done_cycle", dnCyc, 4);
    checkOutput("flc_error", errSeen, 0);
    checkOutput("flc_shiftamt", amt, 6);
    checkOutput("flc_tc", TotalCoeff, 6);
    checkOutput("flc_t1", TrailingOnes, 2);

    // FLC 000111 at the nC=8 boundary: T1 exceeds TC
    applyStimulus(5'd8, 1'b0, 16'h1C00, shCyc, dnCyc, errSeen, amt);
    checkOutput("flcerr_no_shift", shCyc, -1);
    checkOutput("flcerr_done_cycle", dnCyc, 3);
    checkOutput("flcerr_error", errSeen, 1);
    checkOutput("flcerr_tc_held", TotalCoeff, 6);
    checkOutput("flcerr_t1_held", TrailingOnes, 2);

    // All-zero window
    applyStimulus(5'd5, 1'b0, 16'h0000, shCyc, dnCyc, errSeen, amt);
    checkOutput("lz16_no_shift", shCyc, -1);
    checkOutput("lz16_done_cycle", dnCyc, 2);
    checkOutput("lz16_error", errSeen, 1);
    checkOutput("lz16_tc_held", TotalCoeff, 6);
    checkOutput("lz16_t1_held", TrailingOnes, 2);

    // nC=4 -> class 2, Lz=3; mock returns NumShift=17
    applyStimulus(5'd4, 1'b0, 16'h1000, shCyc, dnCyc, errSeen, amt);
    checkOutput("ns17_lutsel", LutSel, 7'h23);
    checkOutput("ns17_no_shift", shCyc, -1);
    checkOutput("ns17_error", errSeen, 1);
    checkOutput("ns17_shiftamt_held", ShiftAmt, 6);

    // Chroma DC overrides nC; NumShift=0
    applyStimulus(5'd12, 1'b1, 16'h2C00, shCyc, dnCyc, errSeen, amt);
    checkOutput("cdc_lutsel", LutSel, 7'h42);
    checkOutput("cdc_lutbits", LutBits, 8'h60);
    checkOutput("cdc_no_shift", shCyc, -1);
    checkOutput("cdc_done_cycle", dnCyc, 3);
    checkOutput("cdc_error", errSeen, 1);

    // FLC escape 000011 at nC=16
    applyStimulus(5'd16, 1'b0, 16'h0C00, shCyc, dnCyc, errSeen, amt);
    checkOutput("esc_done_cycle", dnCyc, 4);
    checkOutput("esc_shiftamt", amt, 6);
    checkOutput("esc_tc", TotalCoeff, 0);
    checkOutput("esc_t1", TrailingOnes, 0);

    // Stall in WAIT with BitsValid low; a second Start meanwhile must be ignored
    @(posedge Clk);
    #1;
    BitsValid = 1'b0; nC = 5'd0; ChromaDC = 1'b0; BitsIn = 16'h8000; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    sawPulse = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      if (ShiftEn || Done) sawPulse = 1'b1;
      checkOutput("stall_busy", Busy, 1);
      Start = (k == 2);
      if (k == 2) nC = 5'd9;
    end
    checkOutput("stall_no_pulse", sawPulse, 0);
    @(posedge Clk);
    #1 BitsValid = 1'b1; Start = 1'b0;
    shCyc = -1; dnCyc = -1; sawPulse = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (ShiftEn) begin
        if (shCyc < 0) shCyc = k; else sawPulse = 1'b1;
        amt = ShiftAmt;
      end
      if (Done) begin
        if (dnCyc < 0) dnCyc = k; else sawPulse = 1'b1;
      end
    end
    checkOutput("stall_shift_cycle", shCyc, 3);
    checkOutput("stall_done_cycle", dnCyc, 4);
    checkOutput("stall_shiftamt", amt, 1);
    checkOutput("stall_second_start_ignored", sawPulse, 0);
    checkOutput("stall_idle_after", Busy, 0);

    // Reset landing in SHIFT
    @(posedge Clk);
    #1;
    nC = 5'd2; ChromaDC = 1'b0; BitsIn = 16'h5A00; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(negedge Clk);
    checkOutput("rstshift_busy_before", Busy, 1);
    checkOutput("rstshift_no_shiften", ShiftEn, 0);
    checkOutput("rstshift_no_done", Done, 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    sawPulse = 1'b0;
    @(negedge Clk);
    checkOutput("rstshift_busy_after", Busy, 0);
    checkOutput("rstshift_shiftamt", ShiftAmt, 0);
    checkOutput("rstshift_tc", TotalCoeff, 0);
    checkOutput("rstshift_t1", TrailingOnes, 0);
    checkOutput("rstshift_lutsel", LutSel, 0);
    checkOutput("rstshift_lutbits", LutBits, 0);
    for (int k = 0; k < 4; k++) begin
      if (ShiftEn || Done || Error) sawPulse = 1'b1;
      @(negedge Clk);
    end
    checkOutput("rstshift_quiet", sawPulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
